// File: rtl/serial_frame_arbiter.sv
// serial_frame_arbiter: round-robin arbiter over three requesters that serialises the winner's frame MSB first.
// Define FRAME_CHECKSUM_EN to append an XOR checksum byte after the payload.
module serial_frame_arbiter #(
  parameter int CLK_DIV  = 16,
  parameter int GAP_BITS = 4
) (
  input  logic        clk_out1,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [23:0] payload0,
  input  logic [23:0] payload1,
  input  logic [23:0] payload2,
  output logic [2:0]  gnt,
  output logic [1:0]  active_id,
  output logic        busy,
  output logic        frame_done,
  output logic        serial_out
);
`ifdef FRAME_CHECKSUM_EN
  localparam int FB = 64;
`else
  localparam int FB = 56;
`endif
  localparam int DW = $clog2(CLK_DIV);
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
  state_t        r_state, w_next;
  logic [DW-1:0] r_div;
  logic [6:0]    r_cnt;
  logic [1:0]    r_last, r_active;
  logic [FB-1:0] r_shift;
  logic [2:0]    r_gnt;
  logic          r_done;
  logic          w_tick, w_end, w_arb, w_grant;
  logic [1:0]    w_p1, w_p2, w_sel;
  logic [23:0]   w_pay;
  logic [FB-1:0] w_frame;
  always_ff @(posedge clk_out1)
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  always_comb begin
    w_tick  = r_div == DW'(CLK_DIV - 1);
    w_end   = w_tick && r_state == SHIFT && r_cnt == 7'(FB - 1);
    w_arb   = w_tick && (r_state == IDLE || (r_state == GAP && r_cnt == 7'(GAP_BITS - 1)));
    w_p1    = r_last == 2'd2 ? 2'd0 : r_last + 2'd1;
    w_p2    = w_p1 == 2'd2 ? 2'd0 : w_p1 + 2'd1;
    w_sel   = req[w_p1] ? w_p1 : req[w_p2] ? w_p2 : r_last;
    w_grant = w_arb && |req;
    w_pay   = w_sel == 2'd0 ? payload0 : w_sel == 2'd1 ? payload1 : payload2;
`ifdef FRAME_CHECKSUM_EN
    w_frame = {16'hA5A5, w_pay, w_pay[23:16] ^ w_pay[15:8] ^ w_pay[7:0], 16'h5A5A};
`else
    w_frame = {16'hA5A5, w_pay, 16'h5A5A};
`endif
  end
  always_comb begin
    w_next = w_grant ? SHIFT : w_end ? GAP : w_arb ? IDLE : r_state;
  end
  // r_cnt counts bits in SHIFT and idle bit periods in GAP
  always_ff @(posedge clk_out1) begin
    if (reset) begin
      r_div    <= '0;
      r_cnt    <= '0;
      r_last   <= 2'd2;
      r_active <= 2'd0;
      r_shift  <= '0;
      r_gnt    <= 3'b000;
      r_done   <= 1'b0;
    end else begin
      r_div  <= w_tick ? '0 : r_div + DW'(1);
      r_gnt  <= w_grant ? 3'b001 << w_sel : 3'b000;
      r_done <= w_end;
      if (w_grant) begin
        r_shift  <= w_frame;
        r_cnt    <= '0;
        r_last   <= w_sel;
        r_active <= w_sel;
      end else if (w_end || w_arb) begin
        r_cnt <= '0;
      end else if (w_tick && r_state != IDLE) begin
        r_cnt   <= r_cnt + 7'd1;
        r_shift <= r_shift << 1;
      end
    end
  end
  always_comb begin
    gnt        = r_gnt;
    active_id  = r_active;
    busy       = r_state != IDLE;
    frame_done = r_done;
    serial_out = r_state == SHIFT && r_shift[FB-1];
  end
endmodule

// File: tb/tb_serial_frame_arbiter.sv
// tb_serial_frame_arbiter: directed bench for serial_frame_arbiter at CLK_DIV=16, GAP_BITS=4.
// Honours FRAME_CHECKSUM_EN for frame length and expected bit streams.
module tb_serial_frame_arbiter;
  localparam int CD = 16;
  localparam int GB = 4;
`ifdef FRAME_CHECKSUM_EN
  localparam int FB = 64;
  localparam logic [63:0] EXP_A = 64'hA5A5_0A141E_00_5A5A;
  localparam logic [63:0] EXP_B = 64'hA5A5_123456_70_5A5A;
  localparam logic [63:0] EXP_C = 64'hA5A5_0A141F_01_5A5A;
`else
  localparam int FB = 56;
  localparam logic [63:0] EXP_A = 64'h00_A5A5_0A141E_5A5A;
  localparam logic [63:0] EXP_B = 64'h00_A5A5_123456_5A5A;
  localparam logic [63:0] EXP_C = 64'h00_A5A5_0A141F_5A5A;
`endif
  localparam int PERIOD = (FB + GB) * CD;
  logic        clk_out1 = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  req = 3'b000;
  logic [23:0] payload0 = '0, payload1 = '0, payload2 = '0;
  logic [2:0]  gnt;
  logic [1:0]  active_id;
  logic        busy, frame_done, serial_out;
  int          checks = 0, errors = 0;
  int          c, dn, dc;
  logic [63:0] got;
  logic        sod, bl;

  always #5 clk_out1 = ~clk_out1;

  serial_frame_arbiter #(.CLK_DIV(CD), .GAP_BITS(GB)) dut (
    .clk_out1(clk_out1), .reset(reset), .req(req),
    .payload0(payload0), .payload1(payload1), .payload2(payload2),
    .gnt(gnt), .active_id(active_id), .busy(busy),
    .frame_done(frame_done), .serial_out(serial_out)
  );

  task automatic wait_gnt(output int cnt);
    cnt = 0;
    do begin
      @(negedge clk_out1);
      cnt++;
    end while (gnt == 3'b000 && cnt < 3000);
  endtask

  // Starts on the negedge where gnt is seen; ends PERIOD negedges later.
  task automatic capture(output logic [63:0] bits, output int done_n, output int done_cnt,
                         output logic so_done, output logic busy_last);
    bits = '0; done_n = -1; done_cnt = 0; so_done = 1'b1; busy_last = 1'b0;
    for (int n = 0; n < PERIOD; n++) begin
      if (n < FB * CD && n % CD == CD / 2) bits[FB - 1 - n / CD] = serial_out;
      if (frame_done) begin
        done_cnt++;
        if (done_n < 0) done_n = n;
      end
      if (n == FB * CD) so_done = serial_out;
      busy_last = busy;
      @(negedge clk_out1);
    end
  endtask

  task automatic test_reset;
    @(negedge clk_out1);
    reset = 1'b1; payload0 = 24'h0A141E; req = 3'b001;
    repeat (3) @(negedge clk_out1);
    checks++; if (serial_out !== 1'b0) begin errors++; $display("FAIL rst_serial got %b exp 0", serial_out); end
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL rst_gnt got %b exp 000", gnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", frame_done); end
    checks++; if (active_id !== 2'd0) begin errors++; $display("FAIL rst_active got %0d exp 0", active_id); end
    reset = 1'b0;
    wait_gnt(c);
    checks++; if (c != CD) begin errors++; $display("FAIL first_grant_latency got %0d exp %0d", c, CD); end
    checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL first_gnt got %b exp 001", gnt); end
    checks++; if (busy !== 1'b1 || serial_out !== 1'b1) begin errors++; $display("FAIL first_busy_bit got %b%b exp 11", busy, serial_out); end
    req = 3'b000;
  endtask

  task automatic test_single_frame;
    capture(got, dn, dc, sod, bl);
    checks++; if (got !== EXP_A) begin errors++; $display("FAIL frame_a_bits got %h exp %h", got, EXP_A); end
    checks++; if (dn != FB * CD) begin errors++; $display("FAIL frame_a_done_at got %0d exp %0d", dn, FB * CD); end
    checks++; if (dc != 1) begin errors++; $display("FAIL frame_a_done_pulses got %0d exp 1", dc); end
    checks++; if (sod !== 1'b0) begin errors++; $display("FAIL frame_a_serial_after got %b exp 0", sod); end
    checks++; if (bl !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL frame_a_busy_gap got %b%b exp 10", bl, busy); end
  endtask

  task automatic test_owner_change;
    req = 3'b010; payload1 = 24'h123456;
    wait_gnt(c);
    checks++; if (c != CD || gnt !== 3'b010) begin errors++; $display("FAIL owner_gnt got %0d/%b exp %0d/010", c, gnt, CD); end
    checks++; if (active_id !== 2'd1) begin errors++; $display("FAIL owner_active got %0d exp 1", active_id); end
    req = 3'b000; payload1 = 24'hFFFFFF;
    capture(got, dn, dc, sod, bl);
    checks++; if (got !== EXP_B) begin errors++; $display("FAIL owner_bits got %h exp %h", got, EXP_B); end
    checks++; if (dn != FB * CD) begin errors++; $display("FAIL owner_done_at got %0d exp %0d", dn, FB * CD); end
  endtask

  task automatic test_round_robin;
    logic [2:0] ord [3] = '{3'b010, 3'b100, 3'b001};
    @(negedge clk_out1);
    reset = 1'b1;
    repeat (2) @(negedge clk_out1);
    req = 3'b111; reset = 1'b0;
    wait_gnt(c);
    checks++; if (c != CD || gnt !== 3'b001) begin errors++; $display("FAIL rr_first got %0d/%b exp %0d/001", c, gnt, CD); end
    for (int i = 0; i < 3; i++) begin
      wait_gnt(c);
      checks++; if (gnt !== ord[i]) begin errors++; $display("FAIL rr_order%0d got %b exp %b", i, gnt, ord[i]); end
      checks++; if (c != PERIOD) begin errors++; $display("FAIL rr_spacing%0d got %0d exp %0d", i, c, PERIOD); end
    end
    req = 3'b000;
    c = 0;
    while (busy && c < 3000) begin
      @(negedge clk_out1);
      c++;
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_idle got %b exp 0", busy); end
  endtask

  task automatic test_late_request;
    req = 3'b010;
    wait_gnt(c);
    checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL late_first got %b exp 010", gnt); end
    req = 3'b000;
    repeat (300) @(negedge clk_out1);
    req = 3'b001;
    wait_gnt(c);
    checks++; if (c != PERIOD - 300) begin errors++; $display("FAIL late_wait got %0d exp %0d", c, PERIOD - 300); end
    checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL late_gnt got %b exp 001", gnt); end
    req = 3'b000;
  endtask

  task automatic test_reset_midframe;
    @(negedge clk_out1);
    reset = 1'b1;
    repeat (2) @(negedge clk_out1);
    payload0 = 24'hFFFFFF; req = 3'b001; reset = 1'b0;
    wait_gnt(c);
    req = 3'b000;
    repeat (20 * CD + 8) @(negedge clk_out1);
    checks++; if (serial_out !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL mid_bit20 got %b%b exp 11", serial_out, busy); end
    reset = 1'b1;
    @(negedge clk_out1);
    checks++; if (serial_out !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_abort got %b%b exp 00", serial_out, busy); end
    checks++; if (frame_done !== 1'b0 || gnt !== 3'b000) begin errors++; $display("FAIL mid_pulses got %b/%b exp 0/000", frame_done, gnt); end
    payload1 = 24'h0A141F; req = 3'b010; reset = 1'b0;
    wait_gnt(c);
    checks++; if (c != CD || gnt !== 3'b010) begin errors++; $display("FAIL mid_regrant got %0d/%b exp %0d/010", c, gnt, CD); end
    req = 3'b000;
    capture(got, dn, dc, sod, bl);
    checks++; if (got !== EXP_C) begin errors++; $display("FAIL mid_fresh_bits got %h exp %h", got, EXP_C); end
    checks++; if (dn != FB * CD || dc != 1) begin errors++; $display("FAIL mid_fresh_done got %0d/%0d exp %0d/1", dn, dc, FB * CD); end
  endtask

  initial begin
    test_reset;
    test_single_frame;
    test_owner_change;
    test_round_robin;
    test_late_request;
    test_reset_midframe;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog timeout after %0d checks", checks);
    $fatal(1);
  end
endmodule

// File: doc/serial_frame_arbiter.md
SERIAL_FRAME_ARBITER -- requirements
Module: serial_frame_arbiter

Interface
REQ-001 SHALL provide parameter CLK_DIV, default 16, meaning clk_out1 cycles per serial bit (legal range 2..256).
REQ-002 SHALL provide parameter GAP_BITS, default 4, meaning idle bit periods between frames (legal range 1..15).
REQ-003 SHALL provide port clk_out1, input, 1 bit: the clock for all sequential logic.
REQ-004 SHALL provide port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL provide port req, input, 3 bits: per-requester frame request, held until granted.
REQ-006 SHALL provide ports payload0, payload1 and payload2, input, 24 bits each: requester payload, bytes P1,P2,P3 from MSB to LSB.
REQ-007 SHALL provide port gnt, output, 3 bits: one-hot one-clk_out1-cycle pulse marking payload capture.
REQ-008 SHALL provide port active_id, output, 2 bits: index of the requester whose frame is in flight.
REQ-009 SHALL provide port busy, output, 1 bit: high from grant until GAP ends.
REQ-010 SHALL provide port frame_done, output, 1 bit: one-cycle pulse when the last frame bit completes.
REQ-011 SHALL provide port serial_out, output, 1 bit: MSB-first serial frame.

Function
REQ-012 SHALL generate a one-cycle bit tick: the divider counts 0..CLK_DIV-1, ticks at CLK_DIV-1, wraps to 0, and free-runs from reset.
REQ-013 SHALL sequence each frame as header 16'hA5A5, then P1, P2, P3, then delimiter 16'h5A5A (56 bits), MSB first.
REQ-014 SHALL implement states IDLE, SHIFT and GAP, with all transitions occurring only on a tick.
REQ-015 SHALL, in IDLE on a tick with any req bit high, grant exactly one requester, pulse its gnt bit, capture its payload, set active_id and busy, drive header bit 15 onto serial_out, and enter SHIFT.
REQ-016 SHALL hold each bit on serial_out for exactly CLK_DIV cycles, so that if the grant occurs at tick T, bit k is driven from tick T+k.
REQ-017 SHALL, at tick T+56, drive serial_out to 0, pulse frame_done for one cycle, and enter GAP.
REQ-018 SHALL remain in GAP for GAP_BITS ticks and then behave as IDLE on tick T+56+GAP_BITS, so that back-to-back frames start every (56+GAP_BITS)*CLK_DIV cycles.
REQ-019 SHALL arbitrate round-robin with priority order last+1, last+2, last, where last is the most recently granted index.
REQ-020 SHALL ignore req outside an arbitration tick; a request dropped before its grant is lost without error.
REQ-021 SHALL NOT alter the in-flight frame when req or payload changes after grant, including deassertion of the owner's req.
REQ-022 SHALL make requests arriving during SHIFT or GAP wait, with no queue depth beyond the req level.
REQ-023 SHALL drive serial_out to 0 whenever the block is not in SHIFT.

Reset
REQ-024 SHALL, on reset, set serial_out=0, gnt=0, busy=0, frame_done=0, active_id=0, state=IDLE, divider=0, bit counter=0 and last=2, so that req0 wins first.
REQ-025 SHALL, on reset asserted mid-frame, abort the frame immediately with no frame_done pulse.
REQ-026 SHALL, on the first tick after reset release, arbitrate normally.

Configuration
REQ-027 SHALL use macro FRAME_CHECKSUM_EN to control an optional checksum byte.
REQ-028 SHALL, with FRAME_CHECKSUM_EN defined, insert checksum byte P1^P2^P3 between P3 and the delimiter, making the frame 64 bits with frame_done at T+64 and period (64+GAP_BITS) ticks.
REQ-029 SHALL, without FRAME_CHECKSUM_EN, transmit a 56-bit frame with no checksum logic present.

Verification (CLK_DIV=16, GAP_BITS=4)
REQ-030 SHALL verify: req=001, payload0=24'h0A141E -> gnt=001 pulse, bit stream A5A5_0A_14_1E_5A5A, frame_done 56*16 cycles after the grant, and busy low after a further 64 cycles.
REQ-031 SHALL verify: req=111 held continuously -> grant order 0,1,2,0 with successive grants 960 cycles apart.
REQ-032 SHALL verify: req0 asserted mid-frame of req1 -> no gnt until tick T+60, then gnt=001.
REQ-033 SHALL verify: reset pulsed at bit 20 -> serial_out=0, busy=0 and no frame_done next cycle, and a fresh header on the next grant.
REQ-034 SHALL verify: with FRAME_CHECKSUM_EN, payload=24'h0A141F -> byte 8'h01 before 5A5A, and frame_done at tick T+64.
REQ-035 SHALL verify: owner drops req and changes payload after grant -> the captured frame is transmitted unchanged.
